// File: rtl/clk_div_pkg.sv
// ============================================================================
// clk_div_pkg : shared types and helpers for the divided-clock triple
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

    localparam int DIV_PHASE_W = 3;

    typedef enum logic [0:0] {
        ST_ACQUIRE = 1'b0,
        ST_LOCKED  = 1'b1
    } state_e;

    // The divider's triple {clk_f,clk_2f,clk_4f} counts down mod 8.
    function automatic logic [DIV_PHASE_W-1:0] next_phase(input logic [DIV_PHASE_W-1:0] p);
        return p - 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_step_chk.sv
// ============================================================================
// clk_div_step_chk : samples the divided-clock triple and flags good steps
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_step_chk
    import clk_div_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIV_PHASE_W-1:0] i_triple,
    output logic [DIV_PHASE_W-1:0] o_cur,
    output logic                   o_step_valid,
    output logic                   o_good
);

    logic [DIV_PHASE_W-1:0] r_cur_q;
    logic [DIV_PHASE_W-1:0] r_prev_q;
    logic                   r_cur_valid;
    logic                   r_prev_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_q      <= '0;
            r_prev_q     <= '0;
            r_cur_valid  <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            r_cur_q      <= i_triple;
            r_prev_q     <= r_cur_q;
            r_cur_valid  <= 1'b1;
            r_prev_valid <= r_cur_valid;
        end
    end

    assign o_cur        = r_cur_q;
    assign o_step_valid = r_prev_valid;
    assign o_good       = r_prev_valid && (r_cur_q == next_phase(r_prev_q));

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// ============================================================================
// clk_div_monitor : lock/error monitor for the divided clock triple
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int LOCK_CYCLES = 16,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_f_in,
    input  logic                   clk_2f_in,
    input  logic                   clk_4f_in,
    input  logic                   clr_err,
    output logic                   locked,
    output logic                   err_pulse,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic                   lost_lock,
    output logic [DIV_PHASE_W-1:0] phase
);

    localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

    logic [DIV_PHASE_W-1:0] w_cur;
    logic                   w_step_valid;
    logic                   w_good;
    logic                   w_count_evt;
    logic                   w_lose_evt;

    state_e                 r_state;
    logic [GOOD_W-1:0]      r_good_cnt;
    logic [BAD_W-1:0]       r_bad_cnt;
    logic                   r_err_pulse;
    logic [ERR_CNT_W-1:0]   r_err_count;
    logic                   r_lost_lock;

    clk_div_step_chk u_step_chk (
        .clk          (clk),
        .reset        (reset),
        .i_triple     ({clk_f_in, clk_2f_in, clk_4f_in}),
        .o_cur        (w_cur),
        .o_step_valid (w_step_valid),
        .o_good       (w_good)
    );

    assign w_count_evt = w_step_valid && !w_good && (r_state == ST_LOCKED);
    assign w_lose_evt  = w_count_evt && (r_bad_cnt == BAD_W'(UNLOCK_ERRS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_ACQUIRE;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_lost_lock <= 1'b0;
        end else begin
            r_err_pulse <= w_count_evt;

            if (w_step_valid) begin
                case (r_state)
                    ST_ACQUIRE: begin
                        if (!w_good) begin
                            r_good_cnt <= '0;
                        end else if (r_good_cnt == GOOD_W'(LOCK_CYCLES - 1)) begin
                            r_state    <= ST_LOCKED;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_good_cnt <= r_good_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (w_good) begin
                            r_bad_cnt <= '0;
                        end else if (w_lose_evt) begin
                            r_state    <= ST_ACQUIRE;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + 1'b1;
                        end
                    end
                endcase
            end

            // A counted error in the clearing cycle leaves a count of one.
            if (clr_err) begin
                r_err_count <= w_count_evt ? ERR_CNT_W'(1) : '0;
            end else if (w_count_evt && (r_err_count != {ERR_CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end

            if (w_lose_evt) begin
                r_lost_lock <= 1'b1;
            end else if (clr_err) begin
                r_lost_lock <= 1'b0;
            end
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign lost_lock = r_lost_lock;
    assign phase     = w_cur;

endmodule

`default_nettype wire
